// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1-to-4 demux scheduler.
package demux_sched_pkg;
   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;
   localparam int   SINKS      = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;
endpackage

// File: rtl/onehot_demux4.sv
// One-hot decode of the demux enable by its 2-bit select.
module onehot_demux4
   import demux_sched_pkg::*;
(
   input  logic             en,
   input  logic [1:0]       sel,
   output logic [SINKS-1:0] vld
);
   assign vld = en ? (SINKS'(1) << sel) : '0;
endmodule

// File: rtl/demux_scheduler.sv
// Single-entry buffered dispatcher driving a 1-to-4 demux, round-robin
// in bursts of BURST words or routed to a fixed sink.
module demux_scheduler
   import demux_sched_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             mode,
   input  logic [1:0]       fixed_sel,
   input  logic [SINKS-1:0] sink_ready,
   output logic [1:0]       out_sel,
   output logic             out_enable,
   output logic [SINKS-1:0] out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             rotate
);
   state_t           state;
   logic [1:0]       cur, sel_q;
   logic [3:0]       cnt;
   logic [WIDTH-1:0] data_q;
   logic             rotate_q;
   logic             accept, deliver;

   // Only the buffered word's sink matters; a stalled sink blocks everything.
   assign in_ready = (state == EMPTY) | sink_ready[sel_q];
   assign accept   = in_valid & in_ready;
   assign deliver  = (state == FULL) & sink_ready[sel_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= EMPTY;
         cur      <= '0;
         cnt      <= '0;
         sel_q    <= '0;
         data_q   <= '0;
         rotate_q <= 1'b0;
      end else begin
         rotate_q <= 1'b0;
         if (accept) begin
            state  <= FULL;
            data_q <= in_data;
            sel_q  <= (mode == MODE_FIXED) ? fixed_sel : cur;
            // Fixed-route words leave the RR position untouched so RR resumes mid-burst.
            if (mode == MODE_RR) begin
               if (cnt == 4'(BURST - 1)) begin
                  cnt      <= '0;
                  cur      <= cur + 2'd1;
                  rotate_q <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
         end else if (deliver) begin
            state <= EMPTY;
         end
      end
   end

   assign out_enable = (state == FULL);
   assign out_sel    = sel_q;
   assign out_data   = data_q;
   assign rotate     = rotate_q;

   onehot_demux4 u_decode (
      .en  (out_enable),
      .sel (sel_q),
      .vld (out_valid)
   );
endmodule
